// File: rtl/stack_pkg.sv
// Shared definitions for the maze solver's move stack: default sizes,
// sequencer state encoding and the move direction codes stored on the stack.
package stack_pkg;

   localparam int N_DEF     = 2;
   localparam int DEPTH_DEF = 16;
   localparam int AW_DEF    = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REPLAY = 2'd1,
      ST_FIN    = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_RIGHT = 2'd1,
      DIR_DOWN  = 2'd2,
      DIR_LEFT  = 2'd3
   } dir_t;

endpackage

// File: rtl/stack_mem.sv
// DEPTH x N move store: one synchronous write port and two asynchronous
// read ports (stack top and replay pointer).
module stack_mem #(
   parameter int N     = 2,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [N-1:0]  wdata,
   input  logic [AW-1:0] top_addr,
   output logic [N-1:0]  top_data,
   input  logic [AW-1:0] rp_addr,
   output logic [N-1:0]  rp_data
);

   logic [N-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign top_data = mem[top_addr];
   assign rp_data  = mem[rp_addr];

endmodule

// File: rtl/stack_controller.sv
// Move-stack sequencer: arbitrates push/pop/replay requests, owns the stack
// and replay pointers, and streams stored moves bottom-to-top on replay.
module stack_controller
   import stack_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = AW_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_req,
   input  logic [N-1:0] push_data,
   input  logic         pop_req,
   output logic [N-1:0] pop_data,
   output logic         pop_valid,
   input  logic         replay_req,
   output logic [N-1:0] move_data,
   output logic         move_valid,
   input  logic         move_ready,
   output logic         finish,
   output logic         busy,
   output logic         empty,
   output logic         full,
   output logic [AW:0]  count,
   output logic         err
);

   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
   localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);

   state_t       state, state_nxt;
   logic [AW:0]  sp, rd_ptr, top_ptr;
   logic         push_acc, pop_acc, xchg, err_c, hs, last;
   logic         we;
   logic [AW-1:0] waddr;
   logic [N-1:0] top_data, rp_data;

   assign top_ptr = sp - PTR_ONE;
   assign empty   = (sp == '0);
   assign full    = (sp == SP_FULL);
   assign count   = sp;
   assign hs      = (state == ST_REPLAY) && move_ready;
   assign last    = (rd_ptr == top_ptr);

   // Arbitration: replay beats push/pop; losers and guarded requests flag err.
   always_comb begin
      push_acc = 1'b0;
      pop_acc  = 1'b0;
      xchg     = 1'b0;
      err_c    = 1'b0;
      if (state == ST_IDLE) begin
         if (replay_req) begin
            err_c = push_req | pop_req;
         end else if (push_req && pop_req) begin
            if (empty) begin
               push_acc = 1'b1;
               err_c    = 1'b1;
            end else begin
               xchg = 1'b1;
            end
         end else if (push_req) begin
            if (full) err_c = 1'b1;
            else      push_acc = 1'b1;
         end else if (pop_req) begin
            if (empty) err_c = 1'b1;
            else       pop_acc = 1'b1;
         end
      end else begin
         err_c = push_req | pop_req | replay_req;
      end
   end

   assign we    = push_acc | xchg;
   assign waddr = xchg ? top_ptr[AW-1:0] : sp[AW-1:0];

   stack_mem #(.N(N), .DEPTH(DEPTH), .AW(AW)) u_mem (
      .clk      (clk),
      .we       (we),
      .waddr    (waddr),
      .wdata    (push_data),
      .top_addr (top_ptr[AW-1:0]),
      .top_data (top_data),
      .rp_addr  (rd_ptr[AW-1:0]),
      .rp_data  (rp_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (replay_req) state_nxt = empty ? ST_FIN : ST_REPLAY;
         ST_REPLAY: if (hs && last) state_nxt = ST_FIN;
         ST_FIN:    state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy       = (state != ST_IDLE);
      move_valid = (state == ST_REPLAY);
      finish     = (state == ST_FIN);
      move_data  = (state == ST_REPLAY) ? rp_data : '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sp        <= '0;
         rd_ptr    <= '0;
         pop_valid <= 1'b0;
         pop_data  <= '0;
         err       <= 1'b0;
      end else begin
         if (push_acc)     sp <= sp + PTR_ONE;
         else if (pop_acc) sp <= top_ptr;
         if (state == ST_IDLE && replay_req) rd_ptr <= '0;
         else if (hs)                        rd_ptr <= rd_ptr + PTR_ONE;
         pop_valid <= pop_acc | xchg;
         if (pop_acc | xchg) pop_data <= top_data;
         err <= err_c;
      end
   end

endmodule

// File: tb/tb_stack_controller.sv
// Directed bench for stack_controller: vector table plus hand sequences for
// overflow, streaming replay, stalled replay and reset during replay.
module tb_stack_controller;
   import stack_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       push_req = 1'b0, pop_req = 1'b0, replay_req = 1'b0, move_ready = 1'b0;
   logic [1:0] push_data = '0;
   logic [1:0] pop_data, move_data;
   logic       pop_valid, move_valid, finish, busy, empty, full, err;
   logic [4:0] count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   stack_controller dut (
      .clk        (clk),
      .rst        (rst),
      .push_req   (push_req),
      .push_data  (push_data),
      .pop_req    (pop_req),
      .pop_data   (pop_data),
      .pop_valid  (pop_valid),
      .replay_req (replay_req),
      .move_data  (move_data),
      .move_valid (move_valid),
      .move_ready (move_ready),
      .finish     (finish),
      .busy       (busy),
      .empty      (empty),
      .full       (full),
      .count      (count),
      .err        (err)
   );

   typedef struct {
      logic        push;
      logic [1:0]  pd;
      logic        pop;
      logic        rep;
      logic        rdy;
      logic [15:0] exp;
   } vec_t;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, expv);
      end
   endtask

   function automatic logic [15:0] obs();
      return {pop_valid, pop_data, count, empty, full, err, move_valid, move_data, finish, busy};
   endfunction

   function automatic logic [15:0] ex(input logic pv, input logic [1:0] pd, input logic [4:0] c,
                                      input logic e, input logic f, input logic er, input logic mv,
                                      input logic [1:0] md, input logic fi, input logic b);
      return {pv, pd, c, e, f, er, mv, md, fi, b};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      push_req   = 1'b0;
      pop_req    = 1'b0;
      replay_req = 1'b0;
      move_ready = 1'b0;
   endtask

   vec_t       vt[19];
   logic [1:0] expd[3];
   logic [11:0] pat;
   int         idx;
   logic       done, mvp;

   initial begin
      vt[0]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, ex(0, 0, 1, 0, 0, 0, 0, 0, 0, 0)};
      vt[1]  = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, ex(0, 0, 2, 0, 0, 0, 0, 0, 0, 0)};
      vt[2]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b0, ex(0, 0, 3, 0, 0, 0, 0, 0, 0, 0)};
      vt[3]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, ex(0, 0, 4, 0, 0, 0, 0, 0, 0, 0)};
      vt[4]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, ex(1, 0, 3, 0, 0, 0, 0, 0, 0, 0)};
      vt[5]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, ex(1, 3, 2, 0, 0, 0, 0, 0, 0, 0)};
      vt[6]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, ex(1, 2, 1, 0, 0, 0, 0, 0, 0, 0)};
      vt[7]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, ex(1, 1, 0, 1, 0, 0, 0, 0, 0, 0)};
      vt[8]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, ex(0, 1, 0, 1, 0, 1, 0, 0, 0, 0)};
      vt[9]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, ex(0, 1, 0, 1, 0, 0, 0, 0, 0, 0)};
      vt[10] = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b0, ex(0, 1, 1, 0, 0, 1, 0, 0, 0, 0)};
      vt[11] = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, ex(0, 1, 2, 0, 0, 0, 0, 0, 0, 0)};
      vt[12] = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b0, ex(1, 1, 2, 0, 0, 0, 0, 0, 0, 0)};
      vt[13] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, ex(1, 3, 1, 0, 0, 0, 0, 0, 0, 0)};
      vt[14] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, ex(1, 3, 0, 1, 0, 0, 0, 0, 0, 0)};
      vt[15] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, ex(0, 3, 0, 1, 0, 0, 0, 0, 1, 1)};
      vt[16] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, ex(0, 3, 0, 1, 0, 0, 0, 0, 0, 0)};
      vt[17] = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b0, ex(0, 3, 0, 1, 0, 1, 0, 0, 1, 1)};
      vt[18] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, ex(0, 3, 0, 1, 0, 0, 0, 0, 0, 0)};

      #12;
      chk("reset", obs(), ex(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 19; i++) begin
         push_req   = vt[i].push;
         push_data  = vt[i].pd;
         pop_req    = vt[i].pop;
         replay_req = vt[i].rep;
         move_ready = vt[i].rdy;
         step();
         chk($sformatf("vec%0d", i), obs(), vt[i].exp);
      end
      idle_inputs();

      // Fill to full, overflow, then drain in reverse order.
      push_req = 1'b1;
      for (int i = 0; i < 16; i++) begin
         push_data = 2'(i);
         step();
      end
      chk("fill", 16'({count, full, empty}), 16'({5'd16, 2'b10}));
      push_data = 2'd1;
      step();
      chk("overflow", 16'({err, count, full}), 16'({1'b1, 5'd16, 1'b1}));
      push_req = 1'b0;
      pop_req  = 1'b1;
      for (int i = 15; i >= 0; i--) begin
         step();
         chk($sformatf("drain%0d", i), 16'({pop_valid, pop_data}), 16'({1'b1, 2'(i)}));
      end
      pop_req = 1'b0;
      step();
      chk("drained", 16'({empty, pop_valid, err}), 16'(3'b100));

      // Streaming replay with ready held high.
      push_req = 1'b1;
      push_data = 2'd2; step();
      push_data = 2'd1; step();
      push_data = 2'd3; step();
      push_req   = 1'b0;
      replay_req = 1'b1;
      move_ready = 1'b1;
      step();
      chk("rp_first", 16'({move_valid, move_data, busy}), 16'({1'b1, 2'd2, 1'b1}));
      replay_req = 1'b0;
      step();
      chk("rp_second", 16'({move_valid, move_data}), 16'({1'b1, 2'd1}));
      step();
      chk("rp_third", 16'({move_valid, move_data}), 16'({1'b1, 2'd3}));
      step();
      chk("rp_finish", 16'({finish, busy, move_valid, count}), 16'({3'b110, 5'd3}));
      step();
      chk("rp_idle", 16'({finish, busy}), 16'(2'b00));
      move_ready = 1'b0;

      // Stalled replay, with a push attempted mid-replay.
      expd[0] = 2'd2;
      expd[1] = 2'd1;
      expd[2] = 2'd3;
      pat = 12'b0110_1010_1001;
      replay_req = 1'b1;
      step();
      replay_req = 1'b0;
      idx  = 0;
      done = 1'b0;
      for (int k = 0; k < 30 && !done; k++) begin
         move_ready = pat[k % 12];
         push_req   = (k == 2);
         push_data  = 2'd0;
         mvp        = move_valid;
         step();
         push_req = 1'b0;
         if (k == 2) chk("err_in_replay", 16'(err), 16'(1));
         if (mvp && move_ready) idx++;
         if (finish) begin
            done = 1'b1;
            chk("stall_count", 16'(idx), 16'(3));
         end else if (idx < 3) begin
            chk($sformatf("stall_md%0d", k), 16'({move_valid, move_data}), 16'({1'b1, expd[idx]}));
         end
      end
      if (!done) begin
         errors++;
         $display("FAIL stall_timeout got no finish want finish");
      end
      move_ready = 1'b0;
      step();
      chk("stall_after", 16'({count, busy}), 16'({5'd3, 1'b0}));
      pop_req = 1'b1;
      step();
      pop_req = 1'b0;
      chk("stall_top", 16'({pop_valid, pop_data, count}), 16'({1'b1, 2'd3, 5'd2}));

      // Reset in the middle of a replay.
      replay_req = 1'b1;
      step();
      replay_req = 1'b0;
      step();
      chk("pre_reset_busy", 16'({busy, move_valid}), 16'(2'b11));
      #2;
      rst = 1'b0;
      #1;
      chk("mid_reset", obs(), ex(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("post_reset%0d", i), 16'({finish, busy, empty}), 16'(3'b001));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
